// File: rtl/uni_shift_seq.sv
// ---------------------------------------------------------------------------
// uni_shift_seq -- multi-cycle universal shift register sequencer.
//
// A command is accepted in IDLE when start is high. LOAD writes p_in directly.
// Shift and rotate commands with a non-zero amount latch their mode and amount.
// The sequencer then performs one one-bit step per cycle in SHIFT. A single
// DONE cycle is produced when the command completes.
//
// Optional feature macro: UNI_SHIFT_ROTATE_EN
//   defined   : modes 100 (ROTL) and 101 (ROTR) rotate the register.
//   undefined : modes 100/101 are treated like HOLD.
//
// Ports:
//   clk         in   single clock, rising edge
//   reset       in   asynchronous, active-low reset
//   start       in   command request, sampled only in IDLE
//   mode[2:0]   in   000 HOLD, 001 SHL, 010 SHR, 011 LOAD,
//                    100 ROTL, 101 ROTR, 110 ASHR, 111 reserved
//   amount      in   number of one-bit steps (AW bits)
//   p_in        in   parallel load data (N bits)
//   s_in        in   serial fill bit, sampled live on every SHL/SHR step
//   abort       in   cancels a running shift (no step, back to IDLE)
//   p_out       out  register contents
//   s_out       out  bit ejected by the most recent step (registered)
//   busy        out  state == SHIFT
//   done        out  state == DONE (one cycle)
//   o_dbg_state out  current FSM state, for debug and checkers
//
// Handshake: start is a level request. It is taken only on a rising edge
// where the FSM is in IDLE. Requests seen in SHIFT or DONE are dropped, not
// queued. The issuer observes completion through the one-cycle done pulse.
// ---------------------------------------------------------------------------
module uni_shift_seq #(
  parameter int N  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [AW-1:0] amount,
  input  logic [N-1:0]  p_in,
  input  logic          s_in,
  input  logic          abort,
  output logic [N-1:0]  p_out,
  output logic          s_out,
  output logic          busy,
  output logic          done,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROTL = 3'b100;
  localparam logic [2:0] M_ROTR = 3'b101;
  localparam logic [2:0] M_ASHR = 3'b110;

  localparam logic [AW-1:0] REM_ONE = AW'(1);

  state_t        r_state;
  logic [2:0]    r_mode;
  logic [AW-1:0] r_rem;
  logic [N-1:0]  r_p;
  logic          r_s;

  state_t        w_state_nxt;
  logic [2:0]    w_mode_nxt;
  logic [AW-1:0] w_rem_nxt;
  logic [N-1:0]  w_p_nxt;
  logic          w_s_nxt;

  logic [N-1:0]  w_step_p;
  logic          w_step_s;
  logic          w_is_step_mode;

  // Modes that run through SHIFT. Rotates only qualify when the rotate
  // feature is built in. Otherwise they fall through to the HOLD path.
  always_comb begin
    w_is_step_mode = 1'b0;
    case (mode)
      M_SHL, M_SHR, M_ASHR: w_is_step_mode = 1'b1;
`ifdef UNI_SHIFT_ROTATE_EN
      M_ROTL, M_ROTR:       w_is_step_mode = 1'b1;
`endif
      default:              w_is_step_mode = 1'b0;
    endcase
  end

  // One-bit step on the latched mode. s_in is used live, so a changing
  // serial input is followed step by step.
  always_comb begin
    w_step_p = r_p;
    w_step_s = r_s;
    case (r_mode)
      M_SHL: begin
        w_step_p = {r_p[N-2:0], s_in};
        w_step_s = r_p[N-1];
      end
      M_SHR: begin
        w_step_p = {s_in, r_p[N-1:1]};
        w_step_s = r_p[0];
      end
`ifdef UNI_SHIFT_ROTATE_EN
      M_ROTL: begin
        w_step_p = {r_p[N-2:0], r_p[N-1]};
        w_step_s = r_p[N-1];
      end
      M_ROTR: begin
        w_step_p = {r_p[0], r_p[N-1:1]};
        w_step_s = r_p[0];
      end
`endif
      M_ASHR: begin
        w_step_p = {r_p[N-1], r_p[N-1:1]};
        w_step_s = r_p[0];
      end
      default: begin
        w_step_p = r_p;
        w_step_s = r_s;
      end
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_rem_nxt   = r_rem;
    w_p_nxt     = r_p;
    w_s_nxt     = r_s;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (mode == M_LOAD) begin
            w_p_nxt     = p_in;
            w_state_nxt = S_DONE;
          end else if (w_is_step_mode && (amount != '0)) begin
            w_mode_nxt  = mode;
            w_rem_nxt   = amount;
            w_state_nxt = S_SHIFT;
          end else begin
            // HOLD, reserved, disabled rotate, or a zero amount: nothing to do.
            w_state_nxt = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        if (abort) begin
          // Keep the partially shifted value. No done pulse is produced.
          w_rem_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_p_nxt   = w_step_p;
          w_s_nxt   = w_step_s;
          w_rem_nxt = r_rem - REM_ONE;
          if (r_rem == REM_ONE) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_mode  <= M_HOLD;
      r_rem   <= '0;
      r_p     <= '0;
      r_s     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_rem   <= w_rem_nxt;
      r_p     <= w_p_nxt;
      r_s     <= w_s_nxt;
    end
  end

  assign p_out       = r_p;
  assign s_out       = r_s;
  assign busy        = (r_state == S_SHIFT);
  assign done        = (r_state == S_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uni_shift_seq.sv
// ---------------------------------------------------------------------------
// Bench for uni_shift_seq (N=8, AW=4).
//
// The expected result of each command is computed from the command rules as
// a whole: shift by k with fill, rotate by k mod 8, and arithmetic shift via
// a signed shift. The expected value is then queued and compared after the
// command's done pulse. Directed steps cover the reference scenarios. A
// randomized loop then covers modes, amounts (including amount > N), data and
// serial fill.
// ---------------------------------------------------------------------------
module tb_uni_shift_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] mode;
  logic [3:0] amount;
  logic [7:0] p_in;
  logic       s_in;
  logic       abort;
  logic [7:0] p_out;
  logic       s_out;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  int n_vec;
  int n_err;

  // Reference model state and scoreboard of {s_out, p_out} per command.
  logic [7:0] m_p;
  logic       m_s;
  int         exp_busy;
  logic [8:0] exp_q[$];
  logic [7:0] trace[0:63];

  uni_shift_seq #(.N(8), .AW(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .amount      (amount),
    .p_in        (p_in),
    .s_in        (s_in),
    .abort       (abort),
    .p_out       (p_out),
    .s_out       (s_out),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: whole-command result from the command rules.
  task automatic model_cmd(input logic [2:0] m, input int k, input logic [7:0] pin,
                           input logic sin);
    logic [7:0] res;
    logic       so;
    int         x;
    int         sx;
    int         r;
    bit         rot_en;
`ifdef UNI_SHIFT_ROTATE_EN
    rot_en = 1'b1;
`else
    rot_en = 1'b0;
`endif
    res = m_p;
    so  = m_s;
    x   = int'(m_p);
    sx  = int'($signed(m_p));
    exp_busy = 0;
    if (m == 3'b011) begin
      res = pin;
    end else if (k > 0) begin
      case (m)
        3'b001: begin
          exp_busy = k;
          res = (k < 8) ? 8'((x << k) | (sin ? ((1 << k) - 1) : 0)) : (sin ? 8'hFF : 8'h00);
          so  = (k <= 8) ? m_p[8-k] : sin;
        end
        3'b010: begin
          exp_busy = k;
          res = (k < 8) ? 8'((x >> k) | (sin ? ((32'hFF << (8 - k)) & 32'hFF) : 0))
                        : (sin ? 8'hFF : 8'h00);
          so  = (k <= 8) ? m_p[k-1] : sin;
        end
        3'b110: begin
          exp_busy = k;
          res = 8'(sx >>> k);
          so  = (k <= 8) ? m_p[k-1] : m_p[7];
        end
        3'b100: if (rot_en) begin
          exp_busy = k;
          r   = k % 8;
          res = 8'((x << r) | (x >> (8 - r)));
          so  = res[0];
        end
        3'b101: if (rot_en) begin
          exp_busy = k;
          r   = k % 8;
          res = 8'((x >> r) | (x << (8 - r)));
          so  = res[7];
        end
        default: ;
      endcase
    end
    m_p = res;
    m_s = so;
    exp_q.push_back({so, res});
  endtask

  // Driver: issue one command, then follow it to completion and compare.
  task automatic run_cmd(input string tag, input logic [2:0] m, input int k,
                         input logic [7:0] pin, input logic sin);
    int         nbusy;
    int         cyc;
    bit         seen_done;
    logic [8:0] e;
    @(negedge clk);
    start  = 1'b1;
    mode   = m;
    amount = 4'(k);
    p_in   = pin;
    s_in   = sin;
    abort  = 1'($urandom_range(0, 1));   // abort in IDLE must be ignored
    model_cmd(m, k, pin, sin);
    @(negedge clk);
    start  = 1'b0;
    abort  = 1'b0;
    // Inputs changing after acceptance must not disturb the command.
    mode   = 3'($urandom);
    amount = 4'($urandom);
    p_in   = 8'($urandom);
    nbusy     = 0;
    seen_done = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      trace[cyc] = p_out;
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (!busy) break;
      nbusy++;
      // Requests during SHIFT must be dropped.
      start  = 1'($urandom_range(0, 1));
      mode   = 3'b011;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " done_seen"}, 32'(seen_done), 32'd1);
    check({tag, " busy_cycles"}, nbusy, exp_busy);
    check({tag, " busy_with_done"}, 32'(busy), 32'd0);
    e = exp_q.pop_front();
    check({tag, " p_out"}, p_out, e[7:0]);
    check({tag, " s_out"}, 32'(s_out), 32'(e[8]));
    abort = 1'($urandom_range(0, 1));    // abort in DONE must be ignored
    @(negedge clk);
    abort = 1'b0;
    check({tag, " done_single"}, 32'(done), 32'd0);
    check({tag, " idle_after"}, 32'(busy), 32'd0);
    check({tag, " p_hold"}, p_out, e[7:0]);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    m_p    = 8'h00;
    m_s    = 1'b0;
    reset  = 1'b0;
    start  = 1'b0;
    mode   = 3'b000;
    amount = 4'd0;
    p_in   = 8'h00;
    s_in   = 1'b0;
    abort  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset p_out", p_out, 8'h00);
    check("reset s_out", 32'(s_out), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    reset = 1'b1;

    // LOAD right after reset, then SHR by 3 with a trace of every step.
    run_cmd("load_ab", 3'b011, 0, 8'hAB, 1'b0);
    run_cmd("shr3", 3'b010, 3, 8'h00, 1'b1);
    check("shr3 step1", trace[1], 8'hD5);
    check("shr3 step2", trace[2], 8'hEA);
    check("shr3 step3", trace[3], 8'hF5);

    run_cmd("load_cd", 3'b011, 0, 8'hCD, 1'b0);
`ifdef UNI_SHIFT_ROTATE_EN
    run_cmd("rotl4", 3'b100, 4, 8'h00, 1'b0);
    check("rotl4 value", p_out, 8'hDC);
`else
    run_cmd("rotl4_off", 3'b100, 4, 8'h00, 1'b0);
    check("rotl4_off value", p_out, 8'hCD);
`endif
    run_cmd("load_80", 3'b011, 0, 8'h80, 1'b0);
    run_cmd("ashr2", 3'b110, 2, 8'h00, 1'b0);
    check("ashr2 value", p_out, 8'hE0);

    // Abort on the third busy cycle of SHL 5 from 01.
    run_cmd("load_01", 3'b011, 0, 8'h01, 1'b0);
    @(negedge clk);
    start = 1'b1; mode = 3'b001; amount = 4'd5; s_in = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 3'b011; p_in = 8'hFF;
    check("abort busy1", 32'(busy), 32'd1);
    @(negedge clk);
    check("abort busy2", 32'(busy), 32'd1);
    check("abort step1", p_out, 8'h02);
    @(negedge clk);
    check("abort busy3", 32'(busy), 32'd1);
    check("abort step2", p_out, 8'h04);
    abort = 1'b1; start = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    check("abort idle", 32'(busy), 32'd0);
    check("abort no_done", 32'(done), 32'd0);
    check("abort p_kept", p_out, 8'h04);
    check("abort s_out", 32'(s_out), 32'd0);
    @(negedge clk);
    check("abort no_done_late", 32'(done), 32'd0);
    m_p = 8'h04;
    m_s = 1'b0;

    // Zero amount and reserved mode leave the register alone.
    run_cmd("shl0", 3'b001, 0, 8'h00, 1'b1);
    run_cmd("rsvd", 3'b111, 7, 8'h3C, 1'b1);
    run_cmd("hold", 3'b000, 9, 8'h3C, 1'b1);

    // Randomized commands, including amounts larger than the width.
    for (int i = 0; i < 60; i++) begin
      run_cmd("rand", 3'($urandom_range(0, 7)), $urandom_range(0, 15),
              8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a shift, with no clock edge involved.
    run_cmd("load_5a", 3'b011, 0, 8'h5A, 1'b1);
    @(negedge clk);
    start = 1'b1; mode = 3'b001; amount = 4'd6; s_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midreset p_out", p_out, 8'h00);
    check("midreset s_out", 32'(s_out), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    m_p = 8'h00;
    m_s = 1'b0;
    run_cmd("post_reset_load", 3'b011, 0, 8'hC3, 1'b0);

    check("scoreboard empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
